// File: rtl/conv_pkg.sv
// conv_pkg: frame geometry, pixel/window types and window_buffer states shared by the conv pipeline.
package conv_pkg;
  localparam int IMG_WIDTH = 9;
  localparam int IMG_HEIGHT = 9;
  localparam int BITS_PER_PIXEL = 4;
  typedef logic [BITS_PER_PIXEL-1:0] pixel_t;
  typedef pixel_t [2:0][2:0] window_t;
  typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT_DONE, FRAME_END} wb_state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of pixels with a registered read port and a write port.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);
  pixel_t mem [DEPTH];
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/window_buffer.sv
// window_buffer: builds 3x3 raster windows from two line buffers and stalls the stream per interior window.
module window_buffer
  import conv_pkg::*;
(
  input  logic    clk,
  input  logic    n_rst,
  input  logic    pixel_valid,
  input  pixel_t  pixel_in,
  output logic    pixel_ready,
  input  logic    calc_done,
  output window_t pixels,
  output logic    calc_enable,
  output logic    frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  wb_state_t state;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row;
  logic calc_done_q, last_win, xfer, complete;
  pixel_t lb0_q, lb1_q;
  // Line buffers read the column that will be current after this edge, so rdata is ready for the next transfer.
  always_comb begin
    xfer = state == ACCEPT && pixel_valid && pixel_ready;
    complete = row >= RW'(2) && col >= CW'(2);
    col_nxt = state == FRAME_END ? '0 : !xfer ? col : col == COL_LAST ? '0 : col + 1'b1;
  end
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(clk), .we(xfer), .waddr(col), .raddr(col_nxt), .wdata(pixel_in), .rdata(lb0_q)
  );
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(clk), .we(xfer), .waddr(col), .raddr(col_nxt), .wdata(lb0_q), .rdata(lb1_q)
  );
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      pixel_ready <= 1'b0;
      calc_enable <= 1'b0;
      frame_done <= 1'b0;
      pixels <= '0;
      col <= '0;
      row <= '0;
      calc_done_q <= 1'b0;
      last_win <= 1'b0;
    end else begin
      calc_done_q <= calc_done;
      calc_enable <= 1'b0;
      frame_done <= 1'b0;
      col <= col_nxt;
      case (state)
        IDLE: begin
          state <= ACCEPT;
          pixel_ready <= 1'b1;
        end
        ACCEPT: if (xfer) begin
          for (int r = 0; r < 3; r++) begin
            pixels[r][0] <= pixels[r][1];
            pixels[r][1] <= pixels[r][2];
          end
          pixels[0][2] <= lb1_q;
          pixels[1][2] <= lb0_q;
          pixels[2][2] <= pixel_in;
          last_win <= row == ROW_LAST && col == COL_LAST;
          if (col == COL_LAST) row <= row + 1'b1;
          if (complete) begin
            state <= ISSUE;
            pixel_ready <= 1'b0;
            calc_enable <= 1'b1;
          end
        end
        ISSUE: state <= WAIT_DONE;
        WAIT_DONE: if (calc_done && !calc_done_q) begin
          state <= last_win ? FRAME_END : ACCEPT;
          frame_done <= last_win;
          pixel_ready <= !last_win;
        end
        FRAME_END: begin
          state <= ACCEPT;
          pixel_ready <= 1'b1;
          row <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
